pe_cfg_frame_loader: RTL

Configuration-side writer for the PE tile. It accepts 32-bit configuration words over a valid/ready handshake and serialises them LSB-first onto the tile's config shift chain. After a full frame it pulses a latch strobe, which commits the static parameter bits (e.g. the `tide_en`/`tide_rst` selections of the register units) held by the chain. It sits between the fabric configuration port and the PE config chain.

---
 rtl/pe_cfg_frame_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pe_cfg_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : pe_cfg_frame_loader
// Purpose  : Accepts WORD_W-bit configuration words over valid/ready and
//            serialises them LSB-first onto the PE tile config shift chain.
//            After FRAME_WORDS words it pulses cfg_latch to commit the chain.
// Options  : PE_CFG_PARITY_EN - check even parity of each accepted word; a
//            bad word sets the sticky err flag and suppresses the frame latch.
// Revision : 1.0 - initial release
// ============================================================================
module pe_cfg_frame_loader #(
    parameter int WORD_W      = 32,
    parameter int FRAME_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic              word_par,
    input  logic              cfg_abort,
    input  logic              err_clr,
    output logic              cfg_data,
    output logic              cfg_shift,
    output logic              cfg_latch,
    output logic              busy,
    output logic              err,
    output logic [15:0]       frame_count
);

    localparam int C_BC_W = $clog2(WORD_W);
    localparam int C_WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [C_BC_W-1:0] C_LAST_BIT  = C_BC_W'(WORD_W - 1);
    localparam logic [C_WC_W-1:0] C_LAST_WORD = C_WC_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_shreg;
    logic [C_BC_W-1:0]   r_bit_cnt;
    logic [C_WC_W-1:0]   r_word_cnt;
    logic                r_frame_bad;
    logic                r_err;
    logic                r_run;
    logic [15:0]         r_frame_count;

    logic                w_last_bit;
    logic                w_last_word;
    logic                w_accept;
    logic                w_par_bad;
    logic                w_commit;

    assign w_last_bit  = (r_bit_cnt == C_LAST_BIT);
    assign w_last_word = (r_word_cnt == C_LAST_WORD);

    // r_run holds ready low until the first edge after reset release;
    // an abort blocks acceptance in the cycle it is asserted.
    assign word_ready = r_run & ~cfg_abort &
                        ((r_state == ST_IDLE) |
                         ((r_state == ST_SHIFT) & w_last_bit & ~w_last_word));

    assign w_accept = word_valid & word_ready;

`ifdef PE_CFG_PARITY_EN
    assign w_par_bad = ^{word_in, word_par};
`else
    logic w_unused_par;
    assign w_unused_par = word_par;
    assign w_par_bad    = 1'b0;
`endif

    // A good frame commits in LATCH unless an abort lands on that same cycle.
    assign w_commit = (r_state == ST_LATCH) & ~r_frame_bad & ~cfg_abort;

    assign cfg_shift   = (r_state == ST_SHIFT);
    assign cfg_data    = cfg_shift & r_shreg[0];
    assign cfg_latch   = w_commit;
    assign busy        = (r_state != ST_IDLE);
    assign err         = r_err;
    assign frame_count = r_frame_count;

    // Frame sequencer: word load, serial shift, frame commit, abort and error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_frame_bad   <= 1'b0;
            r_err         <= 1'b0;
            r_run         <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_run <= 1'b1;

            // A fresh parity error wins over a simultaneous clear.
            if (w_accept & w_par_bad) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            if (cfg_abort) begin
                r_state     <= ST_IDLE;
                r_word_cnt  <= '0;
                r_frame_bad <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_shreg   <= word_in;
                            r_bit_cnt <= '0;
                            r_state   <= ST_SHIFT;
                            if (w_par_bad) begin
                                r_frame_bad <= 1'b1;
                            end
                        end
                    end
                    ST_SHIFT: begin
                        r_shreg   <= r_shreg >> 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_last_bit) begin
                            if (w_last_word) begin
                                r_word_cnt <= '0;
                                r_state    <= ST_LATCH;
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                                if (w_accept) begin
                                    // Back-to-back word: reload without a bubble.
                                    r_shreg   <= word_in;
                                    r_bit_cnt <= '0;
                                    if (w_par_bad) begin
                                        r_frame_bad <= 1'b1;
                                    end
                                end else begin
                                    // Frame paused; word_cnt is kept for resume.
                                    r_state <= ST_IDLE;
                                end
                            end
                        end
                    end
                    ST_LATCH: begin
                        if (w_commit) begin
                            r_frame_count <= r_frame_count + 16'd1;
                        end
                        r_frame_bad <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
